mm_burst_ctrl: RTL and testbench
================================

# mm_burst_ctrl

- Main-memory burst controller that sits directly downstream of the two-way data cache.
- Consumes the cache's `load`/`store` line requests, `addr_out` and `store_data`; returns `load_data` words and a `complete` pulse.
- Owns a word-addressed backing array and moves one 16-word cache line per request, one word per cycle after a fixed access latency.

## Interface
Parameters:
- `LATENCY`, default 4: wait cycles between request acceptance and the first data word; legal range 1..15.
- `ADDR_W`, default 12: word-address width of the backing array (2^ADDR_W x 32 bits).

Ports:
- `clk`  in  1: the single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `load`  in  1: line-fill request from the cache; level, held until `complete`.
- `store`  in  1: line write-back request from the cache; level, held until `complete`.
- `addr_in`  in  32: byte address (cache `addr_out`); line = `addr_in[ADDR_W+1:6]`, critical word = `addr_in[5:2]`, higher bits ignored.
- `store_data`  in  32: write-back word for the current `word_idx`.
- `load_data`  out  32: fill word, registered.
- `data_valid`  out  1: high on each of the 16 transfer cycles.
- `word_idx`  out  4: word within the line for the current transfer cycle.
- `busy`  out  1: high from acceptance through the `complete` cycle.
- `complete`  out  1: one-cycle pulse at the end of each operation.

## Operation
- States: IDLE, WAIT, XFER, DONE.
- `armed` flag:
  - Set in IDLE when `load`=`store`=0.
  - Cleared on acceptance.
  - Cleared at reset, then set on the first cycle with both requests low.
- IDLE -> WAIT when `armed` and (`load` or `store`). Latch the op (store has priority), the line number and the start index.
- WAIT: count LATENCY cycles, then go to XFER.
- XFER: 16 cycles; `word_idx` advances by 1 mod 16 each cycle.
  - Store: write `mem[{line,word_idx}] <= store_data` each cycle.
  - Load: `load_data <= mem[{line,word_idx}]`, `data_valid`=1.
- DONE: `complete`=1 for one cycle.
  - If the op was a store and `load` is high, go directly to WAIT for a load to the same latched line without re-arm.
  - Otherwise go to IDLE.
- Simultaneous `load`+`store` in IDLE: store, then load, each with its own `complete` pulse.
- Request dropped mid-operation: ignored; the operation runs to completion.
- A request still high after `complete` (except the store->load chain) is not re-served until it has dropped for at least one cycle.
- Reset mid-operation: the state machine returns to IDLE at once. Array contents are not reset; words already written by a partial store remain.
- Reset values: `load_data`=0, `data_valid`=0, `word_idx`=0, `busy`=0, `complete`=0.

## Timing
- Request accepted at cycle T (sampled in IDLE). `busy`=1 from T+1.
- WAIT occupies T+1..T+LATENCY.
- `data_valid` is high T+LATENCY+1..T+LATENCY+16.
- `complete` is high at T+LATENCY+17; `busy` drops at T+LATENCY+18.
- Store path: `store_data` is sampled in the same cycle as its `word_idx`. The cache must present the word for the displayed index combinationally or from its B-port, which is clocked in phase.
- Load path: `load_data` and `word_idx` are aligned in the same cycle.
- Chained store->load: the load's WAIT starts the cycle after the store's `complete`.

## Configuration
- Macro `MM_WRAP_BURST_EN`:
  - Defined: load bursts start at `addr_in[5:2]` (critical word first) and wrap mod 16.
  - Undefined: all bursts start at index 0.
- Stores always start at index 0 in both builds.

## Test plan
- Reset, then preload `mem[0x040..0x04F]` = 0xA000+i; `load`, `addr_in`=0x100, LATENCY=4 -> `data_valid` cycles T+5..T+20 with `word_idx` 0..15 and `load_data` 0xA000..0xA00F; `complete` at T+21.
- `store`, `addr_in`=0x200, `store_data`=0xB000+`word_idx` -> `mem[0x080..0x08F]`=0xB000..0xB00F; one `complete`.
- `load` and `store` both high, `addr_in`=0x140 -> store completes (`complete` #1), load starts WAIT the next cycle and returns the just-stored data; `complete` #2.
- `MM_WRAP_BURST_EN` defined, `load` with `addr_in`=0x11C -> `word_idx` sequence 7..15,0..6. Without the macro -> 0..15.
- `load` held high across `complete` -> no second burst until `load` has been low one cycle; then a new burst starts.
- `rst` asserted at the 5th XFER cycle of a store -> outputs at reset values immediately; words 0..3 written, words 4..15 unchanged; next request is served normally.

Source files
------------

// File: rtl/mm_burst_ctrl.sv
// mm_burst_ctrl: main-memory burst controller for the two-way data cache.
// It owns a word-addressed backing array of 2^ADDR_W x 32 bits. Each load or
// store request moves one 16-word line. Data moves one word per cycle, after
// LATENCY wait cycles.
//
// Ports:
//   clk, rst      single clock, asynchronous active-high reset
//   load, store   level requests from the cache, held until complete
//   addr_in       byte address: line = addr_in[ADDR_W+1:6], critical word = addr_in[5:2]
//   store_data    write-back word for the currently displayed word_idx
//   load_data     registered fill word, aligned with word_idx
//   data_valid    high on each of the 16 transfer cycles
//   word_idx      word within the line for the current transfer cycle
//   busy          high from acceptance through the complete cycle
//   complete      one-cycle pulse at the end of each operation
//
// Optional feature: define MM_WRAP_BURST_EN so that a load starts at
// addr_in[5:2] (critical word first) and wraps mod 16. Stores always start at
// word 0.
module mm_burst_ctrl #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned ADDR_W  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        data_valid,
  output logic [3:0]  word_idx,
  output logic        busy,
  output logic        complete
);

  localparam int unsigned LINE_W = ADDR_W - 4;
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StXfer, StDone} state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic                w_accept;
  logic                w_chain;
  logic                r_armed;
  logic                r_op_store;
  logic [LINE_W-1:0]   r_line;
  // Counts down the WAIT cycles first, then the 16 XFER beats.
  logic [3:0]          r_cnt;
  logic [3:0]          r_idx;
  logic [3:0]          w_idx_inc;
  logic [31:0]         r_load_data;
  logic [3:0]          w_load_start;
  logic [3:0]          w_chain_start;
  logic                w_unused;

  logic [31:0]         r_mem [2**ADDR_W];

`ifdef MM_WRAP_BURST_EN
  logic [3:0] r_crit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_crit <= 4'd0;
    end else if (w_accept) begin
      r_crit <= addr_in[5:2];
    end
  end

  assign w_load_start  = addr_in[5:2];
  // A chained load reuses the critical word latched with the store.
  assign w_chain_start = r_crit;
  assign w_unused      = ^{addr_in[31:ADDR_W+2], addr_in[1:0]};
`else
  assign w_load_start  = 4'd0;
  assign w_chain_start = 4'd0;
  assign w_unused      = ^{addr_in[31:ADDR_W+2], addr_in[5:0]};
`endif

  assign w_idx_inc = r_idx + 4'd1;

  // Next state and state-decoded outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_chain     = 1'b0;
    busy        = 1'b1;
    data_valid  = 1'b0;
    complete    = 1'b0;
    unique case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (r_armed && (load || store)) begin
          w_accept    = 1'b1;
          w_state_nxt = StWait;
        end
      end
      StWait: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = StXfer;
        end
      end
      StXfer: begin
        data_valid = 1'b1;
        if (r_cnt == 4'd0) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        complete = 1'b1;
        // A store with a pending load chains straight into the load.
        // The line stays the same and no re-arm is needed.
        if (r_op_store && load) begin
          w_chain     = 1'b1;
          w_state_nxt = StWait;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed     <= 1'b0;
      r_op_store  <= 1'b0;
      r_line      <= '0;
      r_cnt       <= 4'd0;
      r_idx       <= 4'd0;
      r_load_data <= 32'd0;
    end else begin
      // Requests must be seen low in IDLE before the next one is accepted.
      if (r_state == StIdle && !load && !store) begin
        r_armed <= 1'b1;
      end
      if (w_accept) begin
        r_armed    <= 1'b0;
        r_op_store <= store;
        r_line     <= addr_in[ADDR_W+1:6];
        r_cnt      <= LAT_M1;
        r_idx      <= store ? 4'd0 : w_load_start;
      end else if (w_chain) begin
        r_op_store <= 1'b0;
        r_cnt      <= LAT_M1;
        r_idx      <= w_chain_start;
      end else if (r_state == StWait) begin
        if (r_cnt == 4'd0) begin
          r_cnt <= 4'd15;
          // Prefetch the first word so load_data lines up with word_idx.
          if (!r_op_store) begin
            r_load_data <= r_mem[{r_line, r_idx}];
          end
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end else if (r_state == StXfer) begin
        r_cnt <= r_cnt - 4'd1;
        r_idx <= w_idx_inc;
        if (!r_op_store && r_cnt != 4'd0) begin
          r_load_data <= r_mem[{r_line, w_idx_inc}];
        end
      end
    end
  end

  // The array has no reset. If a store is cut short, its written words stay.
  always_ff @(posedge clk) begin
    if (r_state == StXfer && r_op_store) begin
      r_mem[{r_line, r_idx}] <= store_data;
    end
  end

  assign load_data = r_load_data;
  assign word_idx  = r_idx;

endmodule

// File: tb/tb_mm_burst_ctrl.sv
module tb_mm_burst_ctrl;

  localparam int LAT = 4;

  logic        clk;
  logic        rst;
  logic        load;
  logic        store;
  logic [31:0] addr_in;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        data_valid;
  logic [3:0]  word_idx;
  logic        busy;
  logic        complete;

  logic [31:0] sd_base;
  int          cyc;
  int          checks;
  int          failures;
  bit          mon_en;

  typedef struct {
    bit          is_done;
    bit          chk_data;
    logic [3:0]  idx;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [4096];

  mm_burst_ctrl #(
    .LATENCY (LAT),
    .ADDR_W  (12)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .store      (store),
    .addr_in    (addr_in),
    .store_data (store_data),
    .load_data  (load_data),
    .data_valid (data_valid),
    .word_idx   (word_idx),
    .busy       (busy),
    .complete   (complete)
  );

  // The cache presents the write-back word for the displayed index.
  assign store_data = sd_base + {28'd0, word_idx};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: every transfer beat or complete pulse pops one expectation.
  always @(negedge clk) begin
    if (mon_en && (data_valid || complete)) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_output cyc=%0d valid=%b complete=%b idx=%0d data=%h",
                 cyc, data_valid, complete, word_idx, load_data);
      end else begin
        e = sb.pop_front();
        if (e.is_done) begin
          if (!(complete === 1'b1 && data_valid === 1'b0 && busy === 1'b1 && cyc == e.cyc)) begin
            failures++;
            $display("FAIL complete: got cyc=%0d complete=%b valid=%b busy=%b, want cyc=%0d",
                     cyc, complete, data_valid, busy, e.cyc);
          end
        end else begin
          if (!(data_valid === 1'b1 && complete === 1'b0 && busy === 1'b1 &&
                word_idx === e.idx && cyc == e.cyc &&
                (!e.chk_data || load_data === e.data))) begin
            failures++;
            $display("FAIL beat: got cyc=%0d idx=%0d data=%h valid=%b busy=%b, want cyc=%0d idx=%0d data=%h%s",
                     cyc, word_idx, load_data, data_valid, busy, e.cyc, e.idx, e.data,
                     e.chk_data ? "" : " (data unchecked)");
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] ld_start(input logic [31:0] a);
`ifdef MM_WRAP_BURST_EN
    return a[5:2];
`else
    return (a[5:2] & 4'd0);
`endif
  endfunction

  // Queue the expected beats of one burst, which is accepted in cycle c0.
  task automatic push_burst(input int c0, input bit is_st, input logic [7:0] line,
                            input logic [3:0] start, input logic [31:0] base, input int nbeats);
    exp_t       e;
    logic [3:0] idx;
    for (int k = 0; k < nbeats; k++) begin
      idx = start + 4'(k);
      if (is_st) model[{line, idx}] = base + {28'd0, idx};
      e.is_done  = 1'b0;
      e.chk_data = !is_st;
      e.idx      = idx;
      e.data     = is_st ? 32'd0 : model[{line, idx}];
      e.cyc      = c0 + LAT + 1 + k;
      sb.push_back(e);
    end
    if (nbeats == 16) begin
      e.is_done  = 1'b1;
      e.chk_data = 1'b0;
      e.idx      = 4'd0;
      e.data     = 32'd0;
      e.cyc      = c0 + LAT + 17;
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d expected outputs never appeared, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input bit st, input bit ld,
                        input logic [31:0] base, input bit hold, input int gap);
    int c;
    repeat (gap) @(negedge clk);
    c       = cyc;
    addr_in = a;
    store   = st;
    load    = ld;
    sd_base = base;
    if (st) begin
      push_burst(c, 1'b1, a[13:6], 4'd0, base, 16);
      // The chained load's WAIT starts right after the store's complete.
      if (ld) push_burst(c + LAT + 17, 1'b0, a[13:6], ld_start(a), 32'd0, 16);
    end else begin
      push_burst(c, 1'b0, a[13:6], ld_start(a), 32'd0, 16);
    end
    wait_drain(name);
    if (!hold) begin
      @(negedge clk);
      load  = 1'b0;
      store = 1'b0;
    end
  endtask

  initial begin
    int c;
    checks   = 0;
    failures = 0;
    mon_en   = 1'b0;
    rst      = 1'b1;
    load     = 1'b0;
    store    = 1'b0;
    addr_in  = 32'd0;
    sd_base  = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_word_idx", 32'(word_idx), 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_complete", 32'(complete), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // Preload line 4 (words 0x040..0x04F) with 0xA000+i, then read it back.
    run_op("preload_st", 32'h100, 1'b1, 1'b0, 32'hA000, 1'b0, 2);
    run_op("load_100", 32'h100, 1'b0, 1'b1, 32'd0, 1'b0, 2);
    // Store line 8, then read it back.
    run_op("store_200", 32'h200, 1'b1, 1'b0, 32'hB000, 1'b0, 2);
    run_op("load_200", 32'h200, 1'b0, 1'b1, 32'd0, 1'b0, 2);
    // Load and store together: the store runs first, then the chained load.
    run_op("both_140", 32'h140, 1'b1, 1'b1, 32'hE000, 1'b0, 2);
    // The start word depends on the build: 7 when wrapping is enabled, else 0.
    run_op("load_11c", 32'h11C, 1'b0, 1'b1, 32'd0, 1'b0, 2);

    // Load held high across complete: no new burst until it drops.
    run_op("held_load", 32'h100, 1'b0, 1'b1, 32'd0, 1'b1, 2);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("held_no_rearm_busy", 32'(busy), 32'd0);
    end
    @(negedge clk);
    load = 1'b0;
    run_op("rearm_load", 32'h100, 1'b0, 1'b1, 32'd0, 1'b0, 1);

    // Reset during the 5th XFER cycle of a store to line 0x0C.
    run_op("pre_c000", 32'h300, 1'b1, 1'b0, 32'hC000, 1'b0, 2);
    repeat (2) @(negedge clk);
    c       = cyc;
    addr_in = 32'h300;
    store   = 1'b1;
    sd_base = 32'hD000;
    push_burst(c, 1'b1, 8'h0C, 4'd0, 32'hD000, 4);
    repeat (LAT + 5) @(posedge clk);
    #2;
    rst   = 1'b1;
    store = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data_valid", 32'(data_valid), 32'd0);
    chk("midrst_word_idx", 32'(word_idx), 32'd0);
    chk("midrst_load_data", load_data, 32'd0);
    chk("midrst_complete", 32'(complete), 32'd0);
    wait_drain("partial_store");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Expect 0xD000..0xD003 then 0xC004..0xC00F.
    run_op("after_rst_load", 32'h300, 1'b0, 1'b1, 32'd0, 1'b0, 2);

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations: got %0d want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
